// File: rtl/mem_access_ctrl.sv
// Memory access controller between the CPU datapath and ram_256.
// Splits doublewords into two big-endian word accesses and completes the MFC handshake.
module mem_access_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WAIT    = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Req,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [7:0]  Addr,
  input  logic [63:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [63:0] RData,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [7:0]  MemAddress,
  output logic [32:0] MemDataIn,
  output logic [1:0]  MemSize,
  input  logic [31:0] MemDataOut,
  input  logic        MemMFC
);

  localparam int CW = 16;
  localparam logic [CW-1:0] MIN_W   = CW'(MIN_WAIT);
  localparam logic [CW-1:0] TO_W    = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                   rw_q;
  logic                   sgn_q;
  logic [1:0]             size_q;
  logic [7:0]             addr_q;
  logic [63:0]            wdata_q;
  logic [31:0]            rdata_hi_q;
  logic                   second_q;
  logic                   fault_q;
  logic [CW-1:0]          wait_cnt;
  logic [CW-1:0]          elapsed;
  logic [SYNC_STAGES-1:0] mfc_sync;
  logic                   mfc_s;
  logic                   bus_active;
  logic                   acc_ok;
  logic                   acc_to;
  logic                   req_mis;
  logic [7:0]             cur_addr;
  logic [31:0]            wr_word;

  function automatic logic misaligned(input logic [1:0] sz, input logic [7:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return |a[1:0];
      2'b11:   return |a[2:0];
      default: return 1'b0;
    endcase
  endfunction

  // Right-justified load result, sign- or zero-extended from the access width.
  function automatic logic [63:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sgn);
    logic signed [63:0] r;
    case (sz)
      2'b00:   r = sgn ? {{56{d[7]}}, d[7:0]}   : {56'd0, d[7:0]};
      2'b01:   r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      default: r = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
    endcase
    return r;
  endfunction

  assign mfc_s      = mfc_sync[SYNC_STAGES-1];
  assign req_mis    = misaligned(Size, Addr);
  assign elapsed    = (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt + 1'b1;
  assign bus_active = (state == SETUP) || (state == ACCESS);
  assign cur_addr   = second_q ? addr_q + 8'd4 : addr_q;

  always_comb begin
    wr_word = '0;
    case (size_q)
      2'b00:   wr_word = {24'd0, wdata_q[7:0]};
      2'b01:   wr_word = {16'd0, wdata_q[15:0]};
      2'b10:   wr_word = wdata_q[31:0];
      default: wr_word = second_q ? wdata_q[31:0] : wdata_q[63:32];
    endcase
  end

  assign MemEnable    = (state == ACCESS);
  assign MemReadWrite = bus_active & rw_q;
  assign MemAddress   = bus_active ? cur_addr : 8'd0;
  assign MemSize      = bus_active ? ((size_q == 2'b11) ? 2'b10 : size_q) : 2'b00;
  assign MemDataIn    = bus_active ? {1'b0, wr_word} : 33'd0;
  assign Busy         = (state != IDLE);
  assign Done         = (state == DONE);
  assign Fault        = Done & fault_q;

  always_comb begin
    state_nxt = state;
    acc_ok    = 1'b0;
    acc_to    = 1'b0;
    case (state)
      IDLE:    if (Req) state_nxt = req_mis ? DONE : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        // Stale MFC from the previous access is masked only by the minimum wait.
        if ((elapsed >= MIN_W) && mfc_s) begin
          acc_ok    = 1'b1;
          state_nxt = RELEASE;
        end else if ((TO_W != '0) && (elapsed >= TO_W)) begin
          acc_to    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = ((size_q == 2'b11) && !second_q && !fault_q) ? SETUP : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      fault_q  <= 1'b0;
      second_q <= 1'b0;
      wait_cnt <= '0;
      mfc_sync <= '0;
      RData    <= '0;
    end else begin
      state    <= state_nxt;
      mfc_sync <= {mfc_sync[SYNC_STAGES-2:0], MemMFC};
      wait_cnt <= (state == ACCESS) ? elapsed : '0;
      case (state)
        IDLE: begin
          if (Req) begin
            fault_q  <= req_mis;
            second_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (acc_to) fault_q <= 1'b1;
          // A dword result is committed only once both halves have landed.
          if (acc_ok && rw_q) begin
            if (size_q == 2'b11) begin
              if (second_q) RData <= {rdata_hi_q, MemDataOut};
            end else begin
              RData <= extend(MemDataOut, size_q, sgn_q);
            end
          end
        end
        RELEASE: if (state_nxt == SETUP) second_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if ((state == IDLE) && Req) begin
      rw_q    <= RW;
      size_q  <= Size;
      sgn_q   <= Signed;
      addr_q  <= Addr;
      wdata_q <= WData;
    end
    if ((state == ACCESS) && acc_ok && rw_q && (size_q == 2'b11) && !second_q)
      rdata_hi_q <= MemDataOut;
  end

endmodule
